// File: rtl/inst_cache_pw_if.sv
// Fetch/miss bus of the instruction cache.
//   master : fetch stage + refill/request fabric (drives v_pc, pc, flush, v_fill, fill_line, req_rdy)
//   slave  : inst_cache_pw (drives v_ic_req, local_or_OUT, req_msg, v_inst, inst, hit_cnt, miss_cnt)
// LINE_W must equal 32 * 2^OFF_W of the attached cache.
interface inst_cache_pw_if #(
  parameter int unsigned LINE_W = 128
);
  logic              v_pc;
  logic [31:0]       pc;
  logic              flush;
  logic              v_fill;
  logic [LINE_W-1:0] fill_line;
  logic              req_rdy;
  logic              v_ic_req;
  logic              local_or_OUT;
  logic [47:0]       req_msg;
  logic              v_inst;
  logic [31:0]       inst;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport master (
    output v_pc, pc, flush, v_fill, fill_line, req_rdy,
    input  v_ic_req, local_or_OUT, req_msg, v_inst, inst, hit_cnt, miss_cnt
  );

  modport slave (
    input  v_pc, pc, flush, v_fill, fill_line, req_rdy,
    output v_ic_req, local_or_OUT, req_msg, v_inst, inst, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/inst_cache_pw.sv
// Direct-mapped instruction cache for one ring-network core.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : fetch request/response, miss request (valid/ready), refill line, flush
// Optional feature: define IC_STATS_EN to build saturating hit/miss counters;
//   otherwise hit_cnt/miss_cnt are tied to 0.
// v_inst/inst are combinational: a hit answers in the LOOKUP cycle and a
// refill is bypassed to inst in the same cycle v_fill arrives.
module inst_cache_pw #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned OFF_W   = 2,
  parameter int unsigned TAG_W   = 4,
  parameter logic [1:0]  NODE_ID = 2'b00
) (
  input logic            clk,
  input logic            rst,
  inst_cache_pw_if.slave bus
);
  localparam int unsigned NLINES  = 2 ** INDEX_W;
  localparam int unsigned WORDS   = 2 ** OFF_W;
  localparam int unsigned IDX_LSB = OFF_W + 2;
  localparam int unsigned TAG_LSB = IDX_LSB + INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, REQ, WAIT} state_e;

  state_e             state_q, state_d;
  logic [NLINES-1:0]  valid_q, valid_d;
  logic               flush_pend_q, flush_pend_d;
  logic [31:0]        pc_q, pc_d;

  logic [TAG_W-1:0]           tag_mem  [NLINES];
  logic [WORDS-1:0][31:0]     data_mem [NLINES];
  logic [TAG_W-1:0]           tag_rd_q;
  logic [WORDS-1:0][31:0]     data_rd_q;
  logic [WORDS-1:0][31:0]     fill_words;

  logic               rd_en, tag_we, data_we, hit_c;
  logic               v_inst_c;
  logic [31:0]        inst_c;
  logic [OFF_W-1:0]   cur_word;
  logic [INDEX_W-1:0] cur_idx, rd_idx;
  logic [TAG_W-1:0]   cur_tag;
  logic [1:0]         cur_home;

  // Fields of the latched fetch address; pc is captured when the lookup starts
  assign cur_word   = pc_q[2 +: OFF_W];
  assign cur_idx    = pc_q[IDX_LSB +: INDEX_W];
  assign cur_tag    = pc_q[TAG_LSB +: TAG_W];
  assign cur_home   = cur_tag[TAG_W-1 -: 2];
  assign rd_idx     = bus.pc[IDX_LSB +: INDEX_W];
  assign fill_words = bus.fill_line;
  assign hit_c      = valid_q[cur_idx] && (tag_rd_q == cur_tag);

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    pc_d         = pc_q;
    rd_en        = 1'b0;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    v_inst_c     = 1'b0;
    inst_c       = '0;

    // A flush seen while busy is remembered and applied in the next IDLE cycle
    if (bus.flush && (state_q != IDLE)) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        rd_en = bus.v_pc;
        if (bus.flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (bus.v_pc) begin
          pc_d    = bus.pc;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_c) begin
          v_inst_c = 1'b1;
          inst_c   = data_rd_q[cur_word];
          state_d  = IDLE;
        end else begin
          // Line is invalid until the refill lands; tag is written early
          valid_d[cur_idx] = 1'b0;
          tag_we           = 1'b1;
          state_d          = REQ;
        end
      end
      REQ: begin
        if (bus.req_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (bus.v_fill) begin
          tag_we           = 1'b1;
          data_we          = 1'b1;
          valid_d[cur_idx] = 1'b1;
          v_inst_c         = 1'b1;
          inst_c           = fill_words[cur_word];
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      pc_q         <= pc_d;
    end
  end

  // Tag/data arrays: synchronous read indexed by the incoming pc, write by the latched pc
  always_ff @(posedge clk) begin
    if (tag_we)  tag_mem[cur_idx]  <= cur_tag;
    if (data_we) data_mem[cur_idx] <= fill_words;
    if (rd_en) begin
      tag_rd_q  <= tag_mem[rd_idx];
      data_rd_q <= data_mem[rd_idx];
    end
  end

  assign bus.v_inst       = v_inst_c;
  assign bus.inst         = inst_c;
  assign bus.v_ic_req     = (state_q == REQ);
  assign bus.local_or_OUT = (state_q == REQ) && (cur_home == NODE_ID);
  assign bus.req_msg      = (state_q == REQ) ?
                            {cur_home, 1'b1, NODE_ID, 1'b0, 5'b00110, 5'b00000, pc_q} : 48'h0;

`ifdef IC_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        flush_apply;

  assign flush_apply = (state_q == IDLE) && (bus.flush || flush_pend_q);

  // Saturating lookup statistics, cleared whenever a flush takes effect
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush_apply) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (state_q == LOOKUP) begin
      if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF))    hit_cnt_d  = hit_cnt_q + 32'd1;
      if (!hit_c && (miss_cnt_q != 32'hFFFF_FFFF))  miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.hit_cnt  = 32'h0;
  assign bus.miss_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_inst_cache_pw.sv
// Bench for inst_cache_pw (default parameters): directed scenarios followed
// by random fetch traffic, checked against a per-line cache model.
module tb_inst_cache_pw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_cache_pw_if #(.LINE_W(128)) bus ();

  inst_cache_pw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef IC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: what each line holds, plus pending-flush and statistics
  bit               m_valid [32];
  logic [3:0]       m_tag   [32];
  logic [3:0][31:0] m_data  [32];
  bit               m_pend;
  int unsigned      m_hits, m_miss;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned c);
    return STATS ? c : 32'h0;
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_pend = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic check_cnts(input string tag);
    check_eq({tag, "_hit_cnt"},  bus.hit_cnt,  exp_cnt(m_hits));
    check_eq({tag, "_miss_cnt"}, bus.miss_cnt, exp_cnt(m_miss));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.v_pc = 1'b0; bus.flush = 1'b0; bus.v_fill = 1'b0; bus.req_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Flush from IDLE: takes effect at the next edge
  task automatic do_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_clear();
    check_cnts("flush");
  endtask

  // One fetch from IDLE to IDLE; starts and ends on a falling edge
  task automatic do_fetch(input logic [31:0] a, input logic [127:0] line,
                          input int unsigned rdy_wait, input bit flush_mid);
    int unsigned idx, tg, wd, n, exp_lat;
    bit          exp_hit;
    logic [1:0]  home;
    logic [47:0] exp_msg;
    logic [3:0][31:0] lw;
    idx  = (a >> 4) & 32'd31;
    tg   = (a >> 9) & 32'd15;
    wd   = (a >> 2) & 32'd3;
    home = 2'(tg >> 2);
    lw   = line;
    exp_lat = 1;
    if (m_pend) begin
      model_clear();
      exp_lat = 2;
    end
    exp_hit = m_valid[idx] && (m_tag[idx] == 4'(tg));
    exp_msg = {home, 1'b1, 2'b00, 1'b0, 5'b00110, 5'b00000, a};

    bus.v_pc = 1'b1;
    bus.pc   = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.v_inst && !bus.v_ic_req && n < 10);
    if (!bus.v_inst && !bus.v_ic_req) begin
      check_eq("fetch_timeout", 64'(n), 64'd0);
      do_reset();
      return;
    end

    check_eq("hit_path", bus.v_inst, exp_hit);
    if (bus.v_inst) begin
      check_eq("hit_latency", 64'(n), 64'(exp_lat));
      check_eq("hit_inst", bus.inst, m_data[idx][wd]);
      check_eq("hit_no_req", bus.v_ic_req, 1'b0);
      bus.v_pc = 1'b0;
      m_hits++;
      @(negedge clk);
      check_eq("hit_pulse", {bus.v_inst, bus.inst}, 33'h0);
    end else begin
      check_eq("miss_latency", 64'(n), 64'(exp_lat + 1));
      check_eq("local_or_OUT", bus.local_or_OUT, home == 2'b00);
      check_eq("req_msg", bus.req_msg, exp_msg);
      bus.v_pc = 1'b0;
      m_miss++;
      m_valid[idx] = 1'b0;
      m_tag[idx]   = 4'(tg);
      repeat (rdy_wait) begin
        @(negedge clk);
        check_eq("req_hold", {bus.v_ic_req, bus.req_msg}, {1'b1, exp_msg});
      end
      bus.req_rdy = 1'b1;
      @(negedge clk);
      bus.req_rdy = 1'b0;
      check_eq("req_drop", {bus.v_ic_req, bus.local_or_OUT, bus.req_msg}, 50'h0);
      if (flush_mid) begin
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        m_pend = 1'b1;
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("wait_quiet", bus.v_inst, 1'b0);
      end
      bus.v_fill    = 1'b1;
      bus.fill_line = line;
      #1;
      check_eq("fill_v_inst", bus.v_inst, 1'b1);
      check_eq("fill_inst", bus.inst, lw[wd]);
      @(negedge clk);
      bus.v_fill   = 1'b0;
      m_valid[idx] = 1'b1;
      m_data[idx]  = lw;
      check_eq("fill_pulse", {bus.v_inst, bus.inst}, 33'h0);
    end
    check_cnts("fetch");
  endtask

  initial begin
    logic [127:0] rl;
    logic [31:0]  a;
    bus.v_pc = 1'b0; bus.pc = '0; bus.flush = 1'b0;
    bus.v_fill = 1'b0; bus.fill_line = '0; bus.req_rdy = 1'b0;
    model_clear();

    // Outputs held at zero during reset
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {bus.v_ic_req, bus.local_or_OUT, bus.req_msg, bus.v_inst, bus.inst}, 83'h0);
    check_cnts("rst");
    rst = 1'b0;

    // Local miss with back-pressure, refill bypass, then hit
    do_fetch(32'h0000_0104, 128'h44444444_33333333_22222222_11111111, 3, 1'b0);
    do_fetch(32'h0000_0104, 128'h0, 0, 1'b0);
    // Remote home, same index: evicts, then original address misses again
    do_fetch(32'h0000_1104, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 1'b0);
    do_fetch(32'h0000_0104, 128'h44444444_33333333_22222222_11111111, 0, 1'b0);
    // Flush while waiting for refill: instruction still delivered, line then gone
    do_fetch(32'h0000_2208, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b1);
    do_fetch(32'h0000_2208, {$urandom(), $urandom(), $urandom(), $urandom()}, 2, 1'b0);
    do_fetch(32'h0000_0104, 128'h44444444_33333333_22222222_11111111, 0, 1'b0);
    do_fetch(32'h0000_0104, 128'h0, 0, 1'b0);

    // Asynchronous reset while a request is outstanding
    bus.v_pc = 1'b1;
    bus.pc   = 32'h0000_0340;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_req", bus.v_ic_req, 1'b1);
    #3 rst = 1'b1;
    #1;
    check_eq("rst_async_req", {bus.v_ic_req, bus.local_or_OUT, bus.req_msg}, 50'h0);
    bus.v_pc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_cnts("post_rst");
    bus.v_fill    = 1'b1;
    bus.fill_line = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    check_eq("stray_fill", bus.v_inst, 1'b0);
    @(negedge clk);
    bus.v_fill = 1'b0;
    do_fetch(32'h0000_0104, 128'h44444444_33333333_22222222_11111111, 0, 1'b0);

    // Random traffic over a small address pool to mix hits, misses and aliasing
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 3)) << 11)
        | (32'($urandom_range(0, 1)) << 9) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      rl = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) do_flush();
      do_fetch(a, rl, $urandom_range(0, 3), $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_cache_pw.md
Name: inst_cache_pw

Overview:
- Parametrised, direct-mapped instruction cache for one ring-network core.
- Sits between the PC/fetch stage and the local-memory / OUT_req upload path.
- Returns one 32-bit instruction per fetch and stalls the fetch stage on a miss.
- Generalises the fixed 32×4-word design: configurable index, line size and tag width; back-pressured request handshake; correct local/remote routing; whole-cache flush.

Parameters:
- INDEX_W, 5: line index bits; number of lines = 2^INDEX_W.
- OFF_W, 2: word-offset bits; words per line = 2^OFF_W; LINE_W = 32·2^OFF_W.
- TAG_W, 4: tag bits; must be ≥ 2 (top 2 tag bits form the home-node id).
- NODE_ID, 2'b00: this core's 2-bit ring node id.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- v_pc  in  1  fetch request valid; pc held stable until v_inst.
- pc  in  32  fetch address; [1:0] ignored.
- flush  in  1  invalidate-all request, 1-cycle pulse.
- v_fill  in  1  refill line valid (from ic_download).
- fill_line  in  LINE_W  refill data, word 0 in [31:0].
- req_rdy  in  1  request consumer accepts req_msg this cycle.
- v_ic_req  out  1  miss request valid.
- local_or_OUT  out  1  1 = local memory, 0 = OUT_req upload.
- req_msg  out  48  miss message.
- v_inst  out  1  inst valid, 1-cycle pulse.
- inst  out  32  fetched instruction.
- hit_cnt  out  32  hit count (see Optional Feature).
- miss_cnt  out  32  miss count (see Optional Feature).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, on port rst with clock clk. It forces state IDLE, clears all valid bits and flush_pend, and drives all outputs to 0. Tag/data arrays are not cleared. Reset mid-miss abandons the request, and a subsequent v_fill is ignored.
- Address split:
  - word = pc[OFF_W+1:2]
  - idx = pc[OFF_W+INDEX_W+1:OFF_W+2]
  - tag = next TAG_W bits above idx
  - home = top 2 bits of tag
- Storage:
  - valid bits in flops.
  - tag and data arrays with synchronous read, address idx, read enabled in IDLE when v_pc.
- FSM states IDLE, LOOKUP, REQ, WAIT:
  - IDLE: flush or flush_pend → clear all valid bits and flush_pend this cycle, stay IDLE (flush wins over v_pc). Else v_pc → LOOKUP.
  - LOOKUP: hit = valid[idx] && stored tag == tag.
    - Hit: v_inst=1, inst = data word, → IDLE. Latency is 1 cycle after v_pc is sampled.
    - Miss: clear valid[idx], write the new tag, → REQ.
  - REQ: v_ic_req=1 with req_msg and local_or_OUT held stable until req_rdy. req_rdy sampled high → WAIT. No timeout.
  - WAIT: on v_fill, in the same cycle:
    - write fill_line and tag, set valid[idx];
    - v_inst=1, inst = fill_line word selected by word (bypass);
    - → IDLE.
    - Otherwise stay in WAIT.
- req_msg = {home, 1'b1, NODE_ID, 1'b0, 5'b00110, 5'b00000, pc}.
- local_or_OUT = (home == NODE_ID), valid only while v_ic_req is high; 0 otherwise.
- flush outside IDLE sets flush_pend. The in-flight miss still completes and delivers its instruction; the flush is applied on the next IDLE cycle, before any new lookup.
- v_fill outside WAIT is ignored. v_pc outside IDLE is ignored.
- inst is 0 whenever v_inst=0.

Optional Feature:
- Macro IC_STATS_EN.
- Defined:
  - hit_cnt increments on each LOOKUP hit.
  - miss_cnt increments on each LOOKUP miss.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by rst and by flush being applied.
- Undefined: no counter flops; hit_cnt and miss_cnt are tied to 0.

Test Plan:
- Defaults, after reset, pc=0x00000104, v_pc=1:
  - LOOKUP miss → REQ with v_ic_req=1, local_or_OUT=1, req_msg=0x20C0_0000_0104.
  - Hold req_rdy=0 for 3 cycles → req_msg unchanged; req_rdy=1 → WAIT.
- In WAIT, v_fill=1 with fill_line=0x44444444_33333333_22222222_11111111 → same-cycle v_inst=1, inst=0x22222222.
- Repeat pc=0x00000104 → v_inst=1 one cycle after v_pc, inst=0x22222222, v_ic_req stays 0. With IC_STATS_EN: hit_cnt=1, miss_cnt=1.
- pc=0x00001104 (same idx 0x10, tag 0x8, home 2'b10) → miss, local_or_OUT=0, req_msg=0xA0C0_0000_1104. Refill, then pc=0x104 → miss again (eviction).
- flush asserted during WAIT, then v_fill → inst delivered. Next fetch of the same pc misses (flush applied in IDLE).
- rst asserted in REQ → v_ic_req=0 immediately (async). A later v_fill is ignored, and a fetch of the previously cached pc misses.
